// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl
// Memory-mapped input peripheral. It synchronizes and debounces four push-buttons
// and two slide switches. It latches button presses as sticky events and returns
// status/event words on CPU loads. Reading EVENT clears the events.
//
// Ports
//   clk    : CPU clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   btn    : raw buttons {restart,left,start,right}, active-high, asynchronous
//   sw     : raw slide switches, asynchronous
//   cs     : peripheral select
//   sig_r  : read strobe
//   addr   : byte offset in the window, [3:2] selects the register
//   rdata  : combinational read data
//
// Register map (rdata = 0 unless cs & sig_r)
//   0x0 STATUS     {26'b0, sw_stb[1:0], btn_stb[3:0]}
//   0x4 EVENT      {24'b0, ovf[3:0], evt[3:0]}, cleared by the read
//   0x8 EVENT_PEEK same as EVENT, no clear
//   0xC            0
module btn_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn,
    input  logic [1:0]  sw,
    input  logic        cs,
    input  logic        sig_r,
    input  logic [3:0]  addr,
    output logic [31:0] rdata
);

    localparam int N_IN = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  stb;
    logic [N_IN-1:0]  settle;
    logic [CNT_W-1:0] cnt [N_IN];
    logic [3:0]       press;
    logic [3:0]       evt;
    logic [3:0]       ovf;
    logic             clr;
    logic             unused_addr;

    assign raw = {sw, btn};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // settle[i]: this edge is the last of DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        settle = '0;
        for (int i = 0; i < N_IN; i++) begin
            settle[i] = (sync2[i] != stb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == stb[i]) begin
                    cnt[i] <= '0;
                end else if (settle[i]) begin
                    stb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is a settling edge towards 1, so evt rises on the same edge as stb
    assign press = settle[3:0] & sync2[3:0];
    assign clr   = cs & sig_r & (addr[3:2] == 2'b01);

    // On a simultaneous clear and press the press survives and the overflow history is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt <= '0;
            ovf <= '0;
        end else begin
            evt <= (evt & ~{4{clr}}) | press;
            ovf <= clr ? 4'b0 : (ovf | (press & evt));
        end
    end

    always_comb begin
        rdata = '0;
        if (cs && sig_r) begin
            case (addr[3:2])
                2'b00:   rdata = {26'b0, stb};
                2'b01:   rdata = {24'b0, ovf, evt};
                2'b10:   rdata = {24'b0, ovf, evt};
                default: rdata = '0;
            endcase
        end
    end

    // Byte lane bits are irrelevant because every register is word-wide
    assign unused_addr = ^addr[1:0];

endmodule

// File: tb/tb_btn_input_ctrl.sv
module tb_btn_input_ctrl;

    localparam int D  = 4;
    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic [1:0]  sw;
    logic        cs;
    logic        sig_r;
    logic [3:0]  addr;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    btn_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .sw    (sw),
        .cs    (cs),
        .sig_r (sig_r),
        .addr  (addr),
        .rdata (rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last D samples seen after the
    // two-stage delay all disagree with the accepted level.
    bit [5:0] m_stb;
    bit [3:0] m_evt;
    bit [3:0] m_ovf;
    bit [5:0] rawq [$];
    bit [5:0] win  [$];

    function automatic void model_reset();
        m_stb = '0;
        m_evt = '0;
        m_ovf = '0;
        rawq.delete();
        rawq.push_back(6'd0);
        rawq.push_back(6'd0);
        win.delete();
        for (int k = 0; k < D; k++) win.push_back(6'd0);
    endfunction

    function automatic logic [31:0] model_rdata(input logic c, input logic r, input logic [3:0] a);
        if (!(c && r)) return 32'd0;
        case (a[3:2])
            2'b00:   return {26'd0, m_stb};
            2'b01:   return {24'd0, m_ovf, m_evt};
            2'b10:   return {24'd0, m_ovf, m_evt};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input bit [5:0] raw_now, input bit do_clr);
        bit [5:0] smp;
        bit [5:0] nstb;
        bit       all_diff;
        smp = rawq.pop_front();
        rawq.push_back(raw_now);
        win.push_back(smp);
        if (win.size() > D) void'(win.pop_front());
        nstb = m_stb;
        for (int i = 0; i < 6; i++) begin
            all_diff = 1'b1;
            foreach (win[k]) if (win[k][i] == m_stb[i]) all_diff = 1'b0;
            if (all_diff) nstb[i] = ~m_stb[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (nstb[i] && !m_stb[i]) begin
                m_ovf[i] = do_clr ? 1'b0 : (m_ovf[i] | m_evt[i]);
                m_evt[i] = 1'b1;
            end else if (do_clr) begin
                m_ovf[i] = 1'b0;
                m_evt[i] = 1'b0;
            end
        end
        m_stb = nstb;
    endfunction

    // Every step starts and ends just after a falling edge
    task automatic step(input logic [3:0] b, input logic [1:0] s, input logic c,
                        input logic r, input logic [3:0] a, output logic [31:0] got);
        btn = b; sw = s; cs = c; sig_r = r; addr = a;
        #1;
        got = rdata;
        chk("rdata_vs_model", rdata, model_rdata(c, r, a));
        @(posedge clk);
        model_edge({s, b}, c && r && (a[3:2] == 2'b01));
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [3:0] b, input logic [1:0] s);
        logic [31:0] g;
        for (int k = 0; k < n; k++) step(b, s, 1'b0, 1'b0, 4'h0, g);
    endtask

    task automatic do_reset(input logic [3:0] b, input logic [1:0] s);
        btn = b; sw = s; cs = 1'b1; sig_r = 1'b1; addr = 4'h4;
        reset = 1'b1;
        #1;
        model_reset();
        chk("reset_event", rdata, 32'd0);
        addr = 4'h0;
        #1;
        chk("reset_status", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cs = 1'b0; sig_r = 1'b0;
    endtask

    logic [31:0] g;
    logic [3:0]  rb;
    logic [1:0]  rs;

    initial begin
        reset = 1'b1; btn = '0; sw = '0; cs = 1'b0; sig_r = 1'b0; addr = '0;
        model_reset();
        @(negedge clk);

        // buttons held through reset: accepted D+2 edges after release
        do_reset(4'hF, 2'b00);
        idle(6, 4'hF, 2'b00);
        step(4'hF, 2'b00, 1'b1, 1'b1, 4'h0, g); chk("held_status", g, 32'h0000000F);
        step(4'hF, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("held_event", g, 32'h0000000F);
        idle(8, 4'h0, 2'b00);
        step(4'h0, 2'b00, 1'b1, 1'b1, 4'h8, g); chk("release_no_event", g, 32'h0);

        // glitch shorter than D
        idle(3, 4'h2, 2'b00);
        idle(8, 4'h0, 2'b00);
        step(4'h0, 2'b00, 1'b1, 1'b1, 4'h0, g); chk("glitch_status", g, 32'h0);
        step(4'h0, 2'b00, 1'b1, 1'b1, 4'h8, g); chk("glitch_event", g, 32'h0);

        // single press, peek twice, read-to-clear
        idle(8, 4'h4, 2'b00);
        step(4'h4, 2'b00, 1'b1, 1'b1, 4'h8, g); chk("peek1", g, 32'h04);
        step(4'h4, 2'b00, 1'b1, 1'b1, 4'h8, g); chk("peek2", g, 32'h04);
        step(4'h4, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("read_press", g, 32'h04);
        step(4'h4, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("read_cleared", g, 32'h00);
        idle(8, 4'h0, 2'b00);

        // double press without read -> overflow
        idle(8, 4'h1, 2'b00);
        idle(8, 4'h0, 2'b00);
        idle(8, 4'h1, 2'b00);
        step(4'h1, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("overflow", g, 32'h11);
        step(4'h1, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("overflow_cleared", g, 32'h00);
        idle(8, 4'h0, 2'b00);

        // press settles on the same edge as a clearing read
        idle(5, 4'h8, 2'b00);
        step(4'h8, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("race_old", g, 32'h00);
        step(4'h8, 2'b00, 1'b1, 1'b1, 4'h4, g); chk("race_new", g, 32'h08);

        // switches, deselected read, unused offset
        idle(8, 4'h0, 2'b10);
        step(4'h0, 2'b10, 1'b1, 1'b1, 4'h0, g); chk("sw_status", g, 32'h20);
        idle(8, 4'h2, 2'b10);
        step(4'h2, 2'b10, 1'b0, 1'b1, 4'h4, g); chk("cs_low", g, 32'h0);
        step(4'h2, 2'b10, 1'b1, 1'b1, 4'hC, g); chk("offset_c", g, 32'h0);
        step(4'h2, 2'b10, 1'b1, 1'b1, 4'h4, g); chk("not_cleared", g, 32'h02);

        // reset mid-debounce
        idle(3, 4'h1, 2'b00);
        do_reset(4'h1, 2'b00);
        idle(3, 4'h1, 2'b00);
        step(4'h1, 2'b00, 1'b1, 1'b1, 4'h8, g); chk("mid_reset", g, 32'h0);

        // randomized run against the model
        rb = 4'h1; rs = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(rb, rs);
            end else begin
                for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
                for (int i = 0; i < 2; i++) if ($urandom_range(0, 11) == 0) rs[i] = ~rs[i];
                step(rb, rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     4'($urandom_range(0, 15)), g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
